div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 122 ++++++++++++
 tb/tb_div_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle signed 32-bit divider with MIPS DIV semantics.
// Restoring shift-subtract on operand magnitudes, one quotient bit per cycle, then sign fix-up.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        DivCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivZero,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic [32:0] rem;
  logic [5:0]  cnt;
  logic        sign_a;
  logic        sign_q;

  logic [33:0] shifted;
  logic [33:0] diff;
  logic [32:0] rem_next;
  logic [31:0] quo_next;

  // 0x80000000 maps to the unsigned magnitude 2^31, which fits in 32 bits
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic s, input logic [31:0] v);
    return s ? (32'd0 - v) : v;
  endfunction

  // One restoring step: shift in the next dividend bit and subtract if it fits
  always_comb begin
    shifted = {rem, quo[31]};
    diff    = shifted - {2'b00, dvsr};
    if (diff[33]) begin
      rem_next = shifted[32:0];
      quo_next = {quo[30:0], 1'b0};
    end else begin
      rem_next = diff[32:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

  // Control FSM with registered outputs and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      quo     <= 32'd0;
      dvsr    <= 32'd0;
      rem     <= 33'd0;
      cnt     <= 6'd0;
      sign_a  <= 1'b0;
      sign_q  <= 1'b0;
      Hi      <= 32'd0;
      Lo      <= 32'd0;
      DivZero <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          DivZero <= 1'b0;
          if (DivCtrl) begin
            if (B == 32'd0) begin
              DivZero <= 1'b1;
            end else begin
              quo    <= mag(A);
              dvsr   <= mag(B);
              rem    <= 33'd0;
              sign_a <= A[31];
              sign_q <= A[31] ^ B[31];
              cnt    <= 6'd0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= FIX;
          end
        end
        FIX: begin
          Lo    <= neg_if(sign_q, quo);
          Hi    <= neg_if(sign_a, rem[31:0]);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          DivZero <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against a scoreboard of expected {Lo, Hi} results.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DivZero;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] hold_lo = 32'd0;
  logic [31:0] hold_hi = 32'd0;

  div_unit dut (
    .clk(clk), .reset(reset), .DivCtrl(DivCtrl), .A(A), .B(B),
    .Hi(Hi), .Lo(Lo), .DivZero(DivZero), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // MIPS DIV reference; the overflow case is handled explicitly
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {q, r};
  endfunction

  // Runs one division; inject_k >= 0 re-asserts DivCtrl with B=0 on edge E0+inject_k+1
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int inject_k, input string tag);
    logic [63:0] e;
    bit got;
    got = 1'b0;
    sb_q.push_back({exp_lo, exp_hi});
    @(negedge clk);
    DivCtrl = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    DivCtrl = 1'b0;
    A = $urandom;
    B = $urandom;
    for (int k = 0; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        check({tag, "_dz_start"}, {31'd0, DivZero}, 32'd0);
      end
      if (k == 16) begin
        check({tag, "_hold_lo"}, Lo, hold_lo);
        check({tag, "_hold_hi"}, Hi, hold_hi);
      end
      if (k == 32) check({tag, "_busy_last"}, {31'd0, busy}, 32'd1);
      if (inject_k >= 0 && k == inject_k) begin
        DivCtrl = 1'b1;
        B = 32'd0;
      end
      if (inject_k >= 0 && k == inject_k + 1) begin
        DivCtrl = 1'b0;
        check({tag, "_ignored_dz"}, {31'd0, DivZero}, 32'd0);
      end
      if (done) begin
        got = 1'b1;
        e = sb_q.pop_front();
        check({tag, "_latency"}, k, 32'd33);
        check({tag, "_lo"}, Lo, e[63:32]);
        check({tag, "_hi"}, Hi, e[31:0]);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_dz_end"}, {31'd0, DivZero}, 32'd0);
      end
    end
    if (!got) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    hold_lo = exp_lo;
    hold_hi = exp_hi;
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    bit saw_done;

    reset = 1'b0;
    DivCtrl = 1'b0;
    A = 32'd0;
    B = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    check("rst_flags", {29'd0, DivZero, busy, done}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    run_div(32'd7, 32'd2, 32'h0000_0003, 32'h0000_0001, -1, "pos_pos");

    // Divide by zero with Hi=1, Lo=3 preloaded
    @(negedge clk);
    DivCtrl = 1'b1;
    A = 32'h1234_5678;
    B = 32'd0;
    @(posedge clk);
    #1 DivCtrl = 1'b0;
    @(negedge clk);
    check("dz_flag", {31'd0, DivZero}, 32'd1);
    check("dz_busy_done", {30'd0, busy, done}, 32'd0);
    check("dz_hi", Hi, 32'd1);
    check("dz_lo", Lo, 32'd3);
    @(negedge clk);
    check("dz_one_cycle", {31'd0, DivZero}, 32'd0);
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("dz_no_activity", {31'd0, saw_done}, 32'd0);

    run_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1, "neg_pos");
    run_div(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, -1, "pos_neg");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, -1, "overflow");
    run_div(32'h8000_0000, 32'd1, 32'h8000_0000, 32'h0000_0000, -1, "min_by_one");
    run_div(32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, -1, "small_by_min");

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) rb = rb >> 20;
      if (rb == 32'd0) rb = 32'd5;
      m = model(ra, rb);
      run_div(ra, rb, m[63:32], m[31:0], -1, "random");
    end

    run_div(32'd100, 32'd7, 32'd14, 32'd2, 4, "restart_ignored");

    // Reset in the middle of a division
    @(negedge clk);
    DivCtrl = 1'b1;
    A = 32'd100;
    B = 32'd7;
    @(posedge clk);
    #1 DivCtrl = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_hi", Hi, 32'd0);
    check("abort_lo", Lo, 32'd0);
    check("abort_flags", {29'd0, DivZero, busy, done}, 32'd0);
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    hold_lo = 32'd0;
    hold_hi = 32'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    run_div(32'd9, 32'd3, 32'd3, 32'd0, -1, "after_reset");

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
